// File: rtl/resp2regs_pkg.sv
// resp2regs_pkg
//   Shared constants for the response-to-register bridge: half/full word
//   widths and the layout of the optional status word.
//   Status layout (only used when RESP2REGS_STATUS_EN is defined):
//     [31:16] pop counter, [15:8] zero, [7:0] occupancy (zero-extended).
package resp2regs_pkg;

  localparam int HALF_W         = 32;
  localparam int FULL_W         = 64;

  localparam int STATUS_W       = 32;
  localparam int STATUS_CNT_LSB = 0;
  localparam int STATUS_CNT_W   = 8;
  localparam int STATUS_POP_LSB = 16;
  localparam int STATUS_POP_W   = 16;

  function automatic logic [STATUS_W-1:0] pack_status(
    input logic [STATUS_POP_W-1:0] pop_cnt,
    input logic [STATUS_CNT_W-1:0] occ
  );
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_POP_LSB +: STATUS_POP_W] = pop_cnt;
    s[STATUS_CNT_LSB +: STATUS_CNT_W] = occ;
    return s;
  endfunction

endpackage

// File: rtl/resp2regs_fifo.sv
// resp2regs_fifo
//   Circular buffer of DEPTH 64-bit entries with registered occupancy.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     push, push_data write request / word (ignored when full)
//     pop             read request (ignored when empty)
//     head_data       entry at the read pointer (undefined when empty)
//     full, empty     derived from the registered count
//     count           number of buffered entries, $clog2(DEPTH)+1 bits
module resp2regs_fifo
  import resp2regs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [FULL_W-1:0]        push_data,
  input  logic                     pop,
  output logic [FULL_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [FULL_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/resp2regs.sv
// resp2regs
//   Buffers 64-bit AXI-Stream responses and presents the head entry as two
//   32-bit software-readable halves. The head pops once both halves have
//   been read (strobed), in either order or together.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     resp_TDATA/TVALID/TREADY response stream sink
//     resp_lo, resp_hi         head entry halves, zero when empty
//     resp_avail               at least one entry buffered
//     resp_lo_rd_strobe        software read resp_lo (one-cycle pulse)
//     resp_hi_rd_strobe        software read resp_hi (one-cycle pulse)
//     status                   {pop_count, 8'd0, count}; only built when
//                              the macro RESP2REGS_STATUS_EN is defined
module resp2regs
  import resp2regs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FULL_W-1:0]   resp_TDATA,
  input  logic                resp_TVALID,
  output logic                resp_TREADY,
  output logic [HALF_W-1:0]   resp_lo,
  output logic [HALF_W-1:0]   resp_hi,
  output logic                resp_avail,
  input  logic                resp_lo_rd_strobe,
  input  logic                resp_hi_rd_strobe
`ifdef RESP2REGS_STATUS_EN
  ,
  output logic [STATUS_W-1:0] status
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [FULL_W-1:0] head_data;
  logic              full;
  logic              empty;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic              lo_done;
  logic              hi_done;

  // Ready depends only on the registered count, never on this cycle's inputs.
  assign resp_TREADY = !full;
  assign resp_avail  = !empty;
  assign push        = resp_TVALID && resp_TREADY;

  // Pop when the current strobes plus the remembered flags cover both halves.
  // A repeated strobe on a done half contributes nothing new.
  assign pop = resp_avail
            && (lo_done || resp_lo_rd_strobe)
            && (hi_done || resp_hi_rd_strobe);

  assign resp_lo = resp_avail ? head_data[HALF_W-1:0]      : '0;
  assign resp_hi = resp_avail ? head_data[FULL_W-1:HALF_W] : '0;

  resp2regs_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (resp_TDATA),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Flags only accumulate while an entry is present, so strobes on an
  // empty buffer leave them clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_done <= 1'b0;
      hi_done <= 1'b0;
    end else if (pop) begin
      lo_done <= 1'b0;
      hi_done <= 1'b0;
    end else if (resp_avail) begin
      lo_done <= lo_done || resp_lo_rd_strobe;
      hi_done <= hi_done || resp_hi_rd_strobe;
    end
  end

`ifdef RESP2REGS_STATUS_EN
  logic [STATUS_POP_W-1:0] pop_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pop_count <= '0;
    else if (pop) pop_count <= pop_count + 1'b1;
  end

  assign status = pack_status(pop_count, STATUS_CNT_W'(count));
`endif

endmodule

// File: tb/tb_resp2regs.sv
module tb_resp2regs;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] resp_lo;
  logic [31:0] resp_hi;
  logic        resp_avail;
  logic        lo_s = 1'b0;
  logic        hi_s = 1'b0;
`ifdef RESP2REGS_STATUS_EN
  logic [31:0] status;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: plain queue of words, two "half read" flags, pop tally.
  logic [63:0] mq[$];
  bit          m_lo;
  bit          m_hi;
  logic [15:0] m_pops;

  always #5 clk = ~clk;

  resp2regs #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .resp_TDATA        (tdata),
    .resp_TVALID       (tvalid),
    .resp_TREADY       (tready),
    .resp_lo           (resp_lo),
    .resp_hi           (resp_hi),
    .resp_avail        (resp_avail),
    .resp_lo_rd_strobe (lo_s),
    .resp_hi_rd_strobe (hi_s)
`ifdef RESP2REGS_STATUS_EN
    ,
    .status            (status)
`endif
  );

  function automatic logic [31:0] exp_lo();
    logic [63:0] w;
    if (mq.size() == 0) return 32'h0;
    w = mq[0];
    return w[31:0];
  endfunction

  function automatic logic [31:0] exp_hi();
    logic [63:0] w;
    if (mq.size() == 0) return 32'h0;
    w = mq[0];
    return w[63:32];
  endfunction

  function automatic logic exp_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic exp_avail();
    return mq.size() > 0;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, settle 1ns.
  task automatic step(input logic v, input logic [63:0] d, input logic lo, input logic hi);
    bit acc;
    bit pp;
    @(negedge clk);
    tvalid = v; tdata = d; lo_s = lo; hi_s = hi;
    acc = v && (mq.size() < DEPTH);
    pp  = (mq.size() > 0) && (m_lo || lo) && (m_hi || hi);
    @(posedge clk);
    if (pp) begin
      void'(mq.pop_front());
      m_lo = 0; m_hi = 0;
      m_pops = m_pops + 16'd1;
    end else if (mq.size() > 0) begin
      m_lo = m_lo | lo;
      m_hi = m_hi | hi;
    end
    if (acc) mq.push_back(d);
    #1;
  endtask

  task automatic assert_rst();
    @(negedge clk);
    tvalid = 0; lo_s = 0; hi_s = 0; tdata = '0;
    #2 rst = 1'b1;
    #1;
    mq.delete(); m_lo = 0; m_hi = 0; m_pops = '0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    assert_rst();
    n_cmp++; if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", tready); end
    n_cmp++; if (resp_avail !== 1'b0) begin n_fail++; $display("FAIL reset_avail got=%b want=0", resp_avail); end
    n_cmp++; if (resp_lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h want=0", resp_lo); end
    n_cmp++; if (resp_hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h want=0", resp_hi); end
`ifdef RESP2REGS_STATUS_EN
    n_cmp++; if (status !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h want=0", status); end
`endif
    release_rst();
  endtask

  task automatic test_push_basic();
    step(1, 64'h1111_2222_3333_4444, 0, 0);
    n_cmp++; if (resp_lo !== 32'h3333_4444) begin n_fail++; $display("FAIL basic_lo got=%h want=33334444", resp_lo); end
    n_cmp++; if (resp_hi !== 32'h1111_2222) begin n_fail++; $display("FAIL basic_hi got=%h want=11112222", resp_hi); end
    n_cmp++; if (resp_avail !== 1'b1) begin n_fail++; $display("FAIL basic_avail got=%b want=1", resp_avail); end
  endtask

  task automatic test_repeat_strobe();
    step(0, '0, 1, 0);
    n_cmp++; if (resp_avail !== 1'b1) begin n_fail++; $display("FAIL rep_lo1_avail got=%b want=1", resp_avail); end
    step(0, '0, 1, 0);
    n_cmp++; if (resp_avail !== 1'b1) begin n_fail++; $display("FAIL rep_lo2_avail got=%b want=1", resp_avail); end
    n_cmp++; if (resp_lo !== 32'h3333_4444) begin n_fail++; $display("FAIL rep_lo2_lo got=%h want=33334444", resp_lo); end
    step(0, '0, 0, 1);
    n_cmp++; if (resp_avail !== 1'b0) begin n_fail++; $display("FAIL rep_hi_avail got=%b want=0", resp_avail); end
    n_cmp++; if (resp_lo !== 32'h0 || resp_hi !== 32'h0) begin n_fail++; $display("FAIL rep_hi_zero got=%h_%h want=0_0", resp_hi, resp_lo); end
  endtask

  task automatic test_full();
    logic [63:0] w [5];
    w[0] = 64'hAAAA_AAA1_AAAA_AAA0; w[1] = 64'hBBBB_BBB1_BBBB_BBB0;
    w[2] = 64'hCCCC_CCC1_CCCC_CCC0; w[3] = 64'hDDDD_DDD1_DDDD_DDD0;
    w[4] = 64'hEEEE_EEE1_EEEE_EEE0;
    assert_rst(); release_rst();
    for (int i = 0; i < 4; i++) step(1, w[i], 0, 0);
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b want=0", tready); end
    // Pop A while E is offered: E must not be taken this cycle.
    step(1, w[4], 1, 1);
    n_cmp++; if (tready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready got=%b want=1", tready); end
    n_cmp++; if (resp_lo !== 32'hBBBB_BBB0) begin n_fail++; $display("FAIL full_head_b got=%h want=bbbbbbb0", resp_lo); end
    step(1, w[4], 0, 0);
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL wrap_refull_ready got=%b want=0", tready); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (resp_lo !== w[i][31:0] || resp_hi !== w[i][63:32]) begin
        n_fail++; $display("FAIL wrap_order[%0d] got=%h_%h want=%h", i, resp_hi, resp_lo, w[i]);
      end
      if (i % 2 == 1) begin step(0, '0, 0, 1); step(0, '0, 1, 0); end
      else            begin step(0, '0, 1, 0); step(0, '0, 0, 1); end
    end
    n_cmp++; if (resp_avail !== 1'b0) begin n_fail++; $display("FAIL wrap_drained got=%b want=0", resp_avail); end
  endtask

  task automatic test_reset_mid_pair();
    assert_rst(); release_rst();
    step(1, 64'hA0A0_A0A0_0A0A_0A0A, 0, 0);
    step(0, '0, 0, 1);
    assert_rst();
    n_cmp++; if (resp_avail !== 1'b0) begin n_fail++; $display("FAIL midrst_avail got=%b want=0", resp_avail); end
    n_cmp++; if (tready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b want=1", tready); end
    release_rst();
    step(1, 64'hC0C0_C0C0_0C0C_0C0C, 0, 0);
    step(0, '0, 1, 0);
    n_cmp++; if (resp_avail !== 1'b1) begin n_fail++; $display("FAIL midrst_nopop got=%b want=1", resp_avail); end
    n_cmp++; if (resp_lo !== 32'h0C0C_0C0C) begin n_fail++; $display("FAIL midrst_head got=%h want=0c0c0c0c", resp_lo); end
  endtask

  task automatic test_random();
    int fails_before;
    assert_rst(); release_rst();
    fails_before = n_fail;
    for (int i = 0; i < 400; i++) begin
      int rate;
      rate = ((i / 50) % 2 == 0) ? 2 : 6;
      step(($urandom_range(0, 3) != 0), {$urandom, $urandom},
           ($urandom_range(0, rate) == 0), ($urandom_range(0, rate) == 0));
      n_cmp++;
      if (tready !== exp_ready() || resp_avail !== exp_avail()
          || resp_lo !== exp_lo() || resp_hi !== exp_hi()) begin
        n_fail++;
        if (n_fail - fails_before < 5)
          $display("FAIL rand[%0d] got rdy=%b av=%b %h_%h want rdy=%b av=%b %h_%h", i,
                   tready, resp_avail, resp_hi, resp_lo,
                   exp_ready(), exp_avail(), exp_hi(), exp_lo());
      end
`ifdef RESP2REGS_STATUS_EN
      n_cmp++;
      if (status !== {m_pops, 8'd0, 8'(mq.size())}) begin
        n_fail++; $display("FAIL rand_status[%0d] got=%h want=%h", i, status, {m_pops, 8'd0, 8'(mq.size())});
      end
`endif
    end
  endtask

`ifdef RESP2REGS_STATUS_EN
  task automatic test_status();
    assert_rst(); release_rst();
    for (int i = 0; i < 3; i++) step(1, {$urandom, $urandom}, 0, 0);
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    n_cmp++; if (status !== 32'h0002_0001) begin n_fail++; $display("FAIL status_3p2p got=%h want=00020001", status); end
    assert_rst(); release_rst();
    step(1, 64'h1, 0, 0);
    for (int i = 0; i < 65537; i++) step(1, 64'(i + 2), 1, 1);
    n_cmp++; if (status !== 32'h0001_0001) begin n_fail++; $display("FAIL status_wrap got=%h want=00010001", status); end
  endtask
`endif

  initial begin
    m_lo = 0; m_hi = 0; m_pops = '0;
    test_reset();
    test_push_basic();
    test_repeat_strobe();
    test_full();
    test_reset_mid_pair();
    test_random();
`ifdef RESP2REGS_STATUS_EN
    test_status();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/resp2regs.md
RESP2REGS -- requirements
Module: resp2regs

Interface
REQ-001 Parameter DEPTH, default 4, number of 64-bit response entries buffered; power of two, 2..64.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 resp_TDATA  input  64  response word; [31:0] low half, [63:32] high half.
REQ-005 resp_TVALID  input  1  AXI-Stream valid.
REQ-006 resp_TREADY  output  1  AXI-Stream ready; high when buffer not full.
REQ-007 resp_lo  output  32  low half of head entry; 0 when empty.
REQ-008 resp_hi  output  32  high half of head entry; 0 when empty.
REQ-009 resp_avail  output  1  high when at least one entry buffered.
REQ-010 resp_lo_rd_strobe  input  1  one-cycle pulse: software has read resp_lo.
REQ-011 resp_hi_rd_strobe  input  1  one-cycle pulse: software has read resp_hi.
REQ-012 status  output  32  present only with RESP2REGS_STATUS_EN; see REQ-027.

Function
REQ-013 Transfer on resp_TVALID && resp_TREADY shall write resp_TDATA to the FIFO tail.
REQ-014 resp_TREADY shall be driven from registered occupancy only: high iff count < DEPTH; no combinational path from any input.
REQ-015 Push into empty buffer at edge N shall appear on resp_lo/resp_hi with resp_avail high after edge N (one-cycle latency).
REQ-016 Pair tracking: two flags, lo_done and hi_done, record which halves of the head entry have been strobed.
REQ-017 Head entry shall pop on the cycle where the strobe completing the pair arrives (lo then hi, hi then lo, or both strobes in the same cycle).
REQ-018 Both strobes in the same cycle with both flags clear shall pop immediately.
REQ-019 A repeated strobe on an already-done half shall not pop and shall not change state.
REQ-020 On pop both flags shall clear; next entry (or zeros if empty) visible after the same edge.
REQ-021 Strobes while resp_avail low shall be ignored; flags stay clear.
REQ-022 Push and pop in the same cycle shall leave count unchanged; head advances, tail advances.
REQ-023 When full, resp_TREADY low; a pop that cycle raises resp_TREADY after the edge, never same cycle.
REQ-024 Pointers shall be log2(DEPTH) bits and wrap modulo DEPTH; count shall be log2(DEPTH)+1 bits.

Reset
REQ-025 rst assertion shall asynchronously clear pointers, count, flags and status counter: resp_TREADY=1, resp_avail=0, resp_lo=0, resp_hi=0, status=0.
REQ-026 Reset mid-pair (one flag set) or while full shall discard all buffered entries; no pop reported after deassertion.

Configuration
REQ-027 With macro RESP2REGS_STATUS_EN defined: status = {pop_count[15:0], 8'd0, count zero-extended to 8 bits}; pop_count increments per pop, wraps 0xFFFF->0.
REQ-028 Without RESP2REGS_STATUS_EN: status port and pop counter not built; all other behaviour identical.

Structure
REQ-029 Shared package holds the half-word width constant (32), full-word width constant (64) and status field bit positions.
REQ-030 Storage and pointers in one sub-module, resp2regs_fifo (push/pop/full/empty/count, head data output); pair-tracking logic in the top.

Verification
REQ-031 Push 0x11112222_33334444 into empty FIFO -> next cycle resp_lo=0x33334444, resp_hi=0x11112222, resp_avail=1.
REQ-032 lo strobe, then lo strobe again, then hi strobe -> pop only on hi strobe; resp_avail=0 afterward, outputs 0.
REQ-033 Push DEPTH=4 words A..D with no strobes -> resp_TREADY=0 after 4th; both strobes same cycle -> pop, resp_TREADY=1 next cycle, head=B.
REQ-034 Full FIFO, push attempt held valid while popping -> word accepted only cycle after pop; order A..E preserved across pointer wrap.
REQ-035 hi strobe on entry A, assert rst -> resp_avail=0, resp_TREADY=1; new push C then lo strobe alone -> no pop.
REQ-036 RESP2REGS_STATUS_EN: 3 pushes, 2 pops -> status=0x0002_0001; 65537 pops -> pop_count field wraps to 1.
